// File: rtl/cvp14_mem_responder_if.sv
// Word bus between the CVP14 core and its memory responder.
// The core drives address, strobes, burst qualifier and write data;
// the responder returns registered read data.
interface cvp14_mem_responder_if;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic        V;
  logic [15:0] WrData;
  logic [15:0] DataIn;

  modport master (output Addr, output RD, output WR, output V, output WrData, input DataIn);
  modport slave  (input Addr, input RD, input WR, input V, input WrData, output DataIn);
endinterface

// File: rtl/cvp14_mem_responder.sv
// Memory-side responder for the CVP14 word bus.
// Single-port 16-bit word memory with one-cycle registered read data,
// plus a burst tracker that checks V-qualified bursts for direction,
// address sequencing and length, and reports protocol errors.
// Optional feature: define WRITE_PROTECT_EN to drop writes below
// PROT_LIMIT (the instruction region) and flag them with AccessErr.
module cvp14_mem_responder #(
  parameter int          DEPTH      = 4096,
  parameter int          MAX_BEATS  = 16,
  parameter logic [15:0] ERR_DATA   = 16'hDEAD,
  parameter logic [15:0] PROT_LIMIT = 16'h0400
) (
  input  logic                   Clk1,
  input  logic                   Reset_n,
  cvp14_mem_responder_if.slave   bus,
  output logic                   BurstActive,
  output logic [4:0]             BurstCount,
  output logic                   AccessErr,
  output logic                   ProtErr
);

  localparam int          ADDR_W  = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [4:0]  MAX_B   = 5'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  logic [15:0] mem [DEPTH];

  logic [15:0] data_in_q;
  logic        access_err_q;
  logic        prot_err_q;
  logic        burst_active_q;
  logic [4:0]  burst_count_q;
  logic [4:0]  beats;
  logic [15:0] last_addr;
  state_t      state;

  logic              rd_only;
  logic              wr_only;
  logic              rd_wr_both;
  logic              in_range;
  logic              prot_hit;
  logic [ADDR_W-1:0] mem_idx;
  logic              dir_match;
  logic              seq_ok;

  assign rd_only    = bus.RD & ~bus.WR;
  assign wr_only    = bus.WR & ~bus.RD;
  assign rd_wr_both = bus.RD & bus.WR;
  assign in_range   = ({1'b0, bus.Addr} < DEPTH_L);
  assign mem_idx    = bus.Addr[ADDR_W-1:0];

`ifdef WRITE_PROTECT_EN
  assign prot_hit = (bus.Addr < PROT_LIMIT);
`else
  logic unused_prot_limit;
  assign prot_hit          = 1'b0;
  assign unused_prot_limit = ^PROT_LIMIT;
`endif

  assign dir_match = ((state == RD_BURST) && rd_only) || ((state == WR_BURST) && wr_only);
  assign seq_ok    = (bus.Addr == 16'(last_addr + 16'd1)) && (beats < MAX_B);

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge Clk1) begin
    if (wr_only && in_range && !prot_hit)
      mem[mem_idx] <= bus.WrData;
  end

  // Registered read data and access-error pulse for single accesses.
  always_ff @(posedge Clk1 or negedge Reset_n) begin
    if (!Reset_n) begin
      data_in_q    <= 16'h0000;
      access_err_q <= 1'b0;
    end else begin
      access_err_q <= 1'b0;
      if (rd_only) begin
        if (in_range) begin
          data_in_q <= mem[mem_idx];
        end else begin
          data_in_q    <= ERR_DATA;
          access_err_q <= 1'b1;
        end
      end else if (wr_only) begin
        if (!in_range || prot_hit)
          access_err_q <= 1'b1;
      end
    end
  end

  // Burst tracker: follows V-qualified beats alongside the data path and
  // restarts on any sequencing violation instead of blocking the access.
  always_ff @(posedge Clk1 or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      beats          <= 5'd0;
      last_addr      <= 16'h0000;
      burst_active_q <= 1'b0;
      burst_count_q  <= 5'd0;
      prot_err_q     <= 1'b0;
    end else begin
      prot_err_q <= rd_wr_both;
      case (state)
        IDLE: begin
          if (bus.V && rd_only) begin
            state          <= RD_BURST;
            burst_active_q <= 1'b1;
            beats          <= 5'd1;
            last_addr      <= bus.Addr;
          end else if (bus.V && wr_only) begin
            state          <= WR_BURST;
            burst_active_q <= 1'b1;
            beats          <= 5'd1;
            last_addr      <= bus.Addr;
          end
        end
        RD_BURST, WR_BURST: begin
          if (!bus.V) begin
            burst_count_q  <= beats;
            state          <= IDLE;
            burst_active_q <= 1'b0;
            beats          <= 5'd0;
          end else if (rd_only || wr_only) begin
            if (dir_match && seq_ok) begin
              beats     <= 5'(beats + 5'd1);
              last_addr <= bus.Addr;
            end else begin
              prot_err_q     <= 1'b1;
              burst_count_q  <= beats;
              state          <= rd_only ? RD_BURST : WR_BURST;
              burst_active_q <= 1'b1;
              beats          <= 5'd1;
              last_addr      <= bus.Addr;
            end
          end
        end
        default: begin
          state          <= IDLE;
          burst_active_q <= 1'b0;
          beats          <= 5'd0;
        end
      endcase
    end
  end

  assign bus.DataIn  = data_in_q;
  assign BurstActive = burst_active_q;
  assign BurstCount  = burst_count_q;
  assign AccessErr   = access_err_q;
  assign ProtErr     = prot_err_q;

endmodule
